// File: rtl/seq_mult_ctrl_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier controller.
package seq_mult_ctrl_pkg;

    localparam int unsigned WIDTH     = 8;
    localparam int unsigned ITER_LAST = WIDTH - 1;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StDone = 2'd2
    } state_e;

endpackage

// File: rtl/eight_bit_adder.sv
// Eight-bit ripple-carry adder shared as the multiplier datapath.
module eight_bit_adder (
    input  logic [7:0] x,
    input  logic [7:0] y,
    input  logic       carry_in,
    output logic [7:0] sum,
    output logic       c
);

    logic [8:0] chain;

    assign chain[0] = carry_in;

    for (genvar i = 0; i < 8; i++) begin : g_bit
        assign sum[i]     = x[i] ^ y[i] ^ chain[i];
        assign chain[i+1] = (x[i] & y[i]) | (chain[i] & (x[i] ^ y[i]));
    end

    assign c = chain[8];

endmodule

// File: rtl/seq_mult_ctrl.sv
// 8x8 unsigned shift-and-add multiplier: one add/shift per clock through a single adder,
// valid/ready operand and result ports, synchronous abort of an in-flight job.
module seq_mult_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 abort,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    import seq_mult_ctrl_pkg::*;

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     p_hi_q, p_hi_d;
    logic [WIDTH-1:0]     p_lo_q, p_lo_d;
    logic [2:0]           cnt_q, cnt_d;
    logic                 carry_q, carry_d;
    logic [2*WIDTH-1:0]   product_q, product_d;
    logic                 out_valid_q, out_valid_d;

    logic [WIDTH-1:0]     add_y;
    logic [WIDTH-1:0]     add_sum;
    logic                 add_c;

    assign add_y = p_lo_q[0] ? a_q : '0;

    eight_bit_adder u_adder (
        .x        (p_hi_q),
        .y        (add_y),
        .carry_in (1'b0),
        .sum      (add_sum),
        .c        (add_c)
    );

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        p_hi_d      = p_hi_q;
        p_lo_d      = p_lo_q;
        cnt_d       = cnt_q;
        carry_d     = carry_q;
        product_d   = product_q;
        out_valid_d = out_valid_q;

        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_d     = a;
                    p_lo_d  = b;
                    p_hi_d  = '0;
                    cnt_d   = '0;
                    carry_d = 1'b0;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                if (abort) begin
                    // Abandon the job; the partial product is never committed.
                    state_d = StIdle;
                end else begin
                    // Carry-out becomes the new MSB so 0xFF*0xFF keeps every bit.
                    {p_hi_d, p_lo_d} = {add_c, add_sum, p_lo_q[WIDTH-1:1]};
                    carry_d          = add_c;
                    cnt_d            = cnt_q + 3'd1;
                    if (cnt_q == 3'(ITER_LAST)) begin
                        product_d   = {p_hi_d, p_lo_d};
                        out_valid_d = 1'b1;
                        state_d     = StDone;
                    end
                end
            end
            StDone: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            a_q         <= '0;
            p_hi_q      <= '0;
            p_lo_q      <= '0;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            product_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            p_hi_q      <= p_hi_d;
            p_lo_q      <= p_lo_d;
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            product_q   <= product_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign busy      = (state_q == StBusy);
    assign out_valid = out_valid_q;
    assign product   = product_q;

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Scoreboard bench for seq_mult_ctrl: directed operand pairs with hand-computed products.
module tb_seq_mult_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  a = '0;
    logic [7:0]  b = '0;
    logic        abort = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] product;
    logic        busy;

    int errors = 0;
    int checks = 0;
    logic [15:0] exp_q[$];

    seq_mult_ctrl #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .abort     (abort),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Result port monitor: every completed handshake must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got 0x%0h expected none", product);
            end else begin
                check("product", {16'h0, product}, {16'h0, exp_q.pop_front()});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [7:0] x, input logic [7:0] y);
        in_valid = 1'b1;
        a        = x;
        b        = y;
        step();
        in_valid = 1'b0;
        check("in_ready_drop", {31'h0, in_ready}, 32'h0);
        check("busy_after_accept", {31'h0, busy}, 32'h1);
    endtask

    // Counts edges after the accept edge until out_valid, plus cycles with busy high.
    task automatic run_lat(output int lat, output int busy_cyc);
        lat      = 0;
        busy_cyc = busy ? 1 : 0;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
            if (busy) busy_cyc++;
        end
        check("out_valid_rise", {31'h0, out_valid}, 32'h1);
    endtask

    task automatic do_job(input logic [7:0] x, input logic [7:0] y, input logic [15:0] e);
        int lat;
        int bc;
        issue(x, y);
        exp_q.push_back(e);
        run_lat(lat, bc);
        check("latency", lat, 8);
        step();
        check("out_valid_drop", {31'h0, out_valid}, 32'h0);
        check("in_ready_back", {31'h0, in_ready}, 32'h1);
    endtask

    initial begin
        int lat;
        int bc;
        bit seen;

        // Reset values while rst_n is held low.
        #2;
        check("rst_product", {16'h0, product}, 32'h0);
        check("rst_out_valid", {31'h0, out_valid}, 32'h0);
        check("rst_in_ready", {31'h0, in_ready}, 32'h1);
        check("rst_busy", {31'h0, busy}, 32'h0);
        #10 rst_n = 1'b1;
        step();

        // 1: basic multiply, latency and busy width.
        out_ready = 1'b1;
        issue(8'h0D, 8'h0B);
        exp_q.push_back(16'h008F);
        run_lat(lat, bc);
        check("t1_latency", lat, 8);
        check("t1_busy_cycles", bc, 8);
        step();
        check("t1_in_ready", {31'h0, in_ready}, 32'h1);

        // 2: carry on every iteration, and multiply by zero.
        do_job(8'hFF, 8'hFF, 16'hFE01);
        do_job(8'h00, 8'h5A, 16'h0000);

        // 3: backpressure with the next operand pair already waiting.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        a         = 8'h0C;
        b         = 8'h0A;
        step();
        exp_q.push_back(16'h0078);
        a = 8'h03;
        b = 8'h05;
        run_lat(lat, bc);
        check("t3_latency", lat, 8);
        for (int i = 0; i < 5; i++) begin
            step();
            check("t3_hold_valid", {31'h0, out_valid}, 32'h1);
            check("t3_hold_product", {16'h0, product}, 32'h0078);
            check("t3_hold_in_ready", {31'h0, in_ready}, 32'h0);
        end
        out_ready = 1'b1;
        step();
        check("t3_valid_drop", {31'h0, out_valid}, 32'h0);
        check("t3_in_ready", {31'h0, in_ready}, 32'h1);
        exp_q.push_back(16'h000F);
        step();
        in_valid = 1'b0;
        check("t3_second_accept", {31'h0, busy}, 32'h1);
        run_lat(lat, bc);
        check("t3_second_latency", lat, 8);
        step();

        // 4: operands offered during BUSY are ignored until IDLE.
        issue(8'h07, 8'h09);
        exp_q.push_back(16'h003F);
        in_valid = 1'b1;
        a        = 8'h33;
        b        = 8'h02;
        run_lat(lat, bc);
        check("t4_latency", lat, 8);
        step();
        check("t4_in_ready", {31'h0, in_ready}, 32'h1);
        exp_q.push_back(16'h0066);
        step();
        in_valid = 1'b0;
        check("t4_second_accept", {31'h0, busy}, 32'h1);
        run_lat(lat, bc);
        check("t4_second_latency", lat, 8);
        step();

        // 5: abort sampled at the fourth iteration edge.
        in_valid = 1'b1;
        a        = 8'h10;
        b        = 8'h10;
        step();
        in_valid = 1'b0;
        repeat (3) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("t5_busy", {31'h0, busy}, 32'h0);
        check("t5_in_ready", {31'h0, in_ready}, 32'h1);
        check("t5_product_kept", {16'h0, product}, 32'h0066);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (out_valid) seen = 1'b1;
        end
        check("t5_no_valid", {31'h0, seen}, 32'h0);
        do_job(8'h02, 8'h03, 16'h0006);

        // 6: asynchronous reset mid-BUSY and mid-DONE.
        in_valid = 1'b1;
        a        = 8'h55;
        b        = 8'h03;
        step();
        in_valid = 1'b0;
        repeat (3) step();
        #3 rst_n = 1'b0;
        #1;
        check("t6_busy_rst_product", {16'h0, product}, 32'h0);
        check("t6_busy_rst_valid", {31'h0, out_valid}, 32'h0);
        check("t6_busy_rst_in_ready", {31'h0, in_ready}, 32'h1);
        check("t6_busy_rst_busy", {31'h0, busy}, 32'h0);
        #2 rst_n = 1'b1;
        step();

        out_ready = 1'b0;
        issue(8'h04, 8'h04);
        exp_q.push_back(16'h0010);
        run_lat(lat, bc);
        check("t6_done_product", {16'h0, product}, 32'h0010);
        step();
        #3 rst_n = 1'b0;
        #1;
        check("t6_done_rst_product", {16'h0, product}, 32'h0);
        check("t6_done_rst_valid", {31'h0, out_valid}, 32'h0);
        check("t6_done_rst_in_ready", {31'h0, in_ready}, 32'h1);
        void'(exp_q.pop_back());
        #2 rst_n = 1'b1;
        out_ready = 1'b1;
        step();
        do_job(8'h80, 8'h02, 16'h0100);

        repeat (2) step();
        check("queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
